// File: rtl/ddr_lat_pkg.sv
// Shared definitions for the DDR latency-alignment blocks.
//   lat_state_e   : delay-change FSM states (RUN / DRAIN / APPLY)
//   clamp_dly     : clamps a requested delay into 1..max_dly
//   dly_illegal   : flags a requested delay outside 1..max_dly
package ddr_lat_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2
  } lat_state_e;

  function automatic int unsigned clamp_dly(input int unsigned val,
                                            input int unsigned max_dly);
    if (val == 0)            return 1;
    else if (val > max_dly)  return max_dly;
    else                     return val;
  endfunction

  function automatic logic dly_illegal(input int unsigned val,
                                       input int unsigned max_dly);
    return (val == 0) || (val > max_dly);
  endfunction

endpackage

// File: rtl/var_lat_pipe_if.sv
// Beat stream + delay-control bundle for var_lat_pipe.
//   in_vld/in_data/in_rdy     : input beat handshake
//   out_vld/out_data          : delayed output beat
//   dly_req/dly_val/dly_ack   : runtime delay change request / acknowledge
//   dly_cur/busy/cfg_err      : status
// Modports: slave = pipeline side, master = driver side.
interface var_lat_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DLY_W = 5
) ();
  logic             in_vld;
  logic [WIDTH-1:0] in_data;
  logic             in_rdy;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             dly_req;
  logic [DLY_W-1:0] dly_val;
  logic             dly_ack;
  logic [DLY_W-1:0] dly_cur;
  logic             busy;
  logic             cfg_err;

  modport slave (
    input  in_vld, in_data, dly_req, dly_val,
    output in_rdy, out_vld, out_data, dly_ack, dly_cur, busy, cfg_err
  );

  modport master (
    output in_vld, in_data, dly_req, dly_val,
    input  in_rdy, out_vld, out_data, dly_ack, dly_cur, busy, cfg_err
  );
endinterface

// File: rtl/lat_stage.sv
// One {vld,data} register stage of the latency pipeline.
//   clk, rst (async, active-low)
//   clr             : synchronous clear of the valid bit
//   d_vld, d_data   : stage input
//   q_vld, q_data   : registered stage output
module lat_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             d_vld,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_vld,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_vld  <= 1'b0;
      q_data <= '0;
    end else begin
      q_vld  <= d_vld & ~clr;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/var_lat_pipe.sv
// Runtime-programmable delay pipeline with valid qualifier. A beat accepted at
// the input appears at the output exactly dly_cur cycles later. Delay changes
// drain in-flight beats before the new tap is applied.
//   clk, rst (async, active-low)
//   bus (slave) : beat handshake, delay request/ack and status
module var_lat_pipe
  import ddr_lat_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned RST_DLY   = 3
) (
  input  logic           clk,
  input  logic           rst,
  var_lat_pipe_if.slave  bus
);

  localparam int unsigned DLY_W = $clog2(MAX_DEPTH + 1);
  localparam int unsigned TAP_W = $clog2(MAX_DEPTH);

  lat_state_e       state, state_nx;
  logic [DLY_W-1:0] dly_cur, pending, inflight;
  logic             cfg_err;
  logic             in_rdy, accept, out_vld, dly_ack, clr_vld, drained;
  logic [TAP_W-1:0] tap;
  logic [DLY_W-1:0] req_clamped;
  logic             req_bad;

  logic [MAX_DEPTH-1:0] d_vld, stg_vld;
  logic [WIDTH-1:0]     d_data   [MAX_DEPTH];
  logic [WIDTH-1:0]     stg_data [MAX_DEPTH];

  assign accept = bus.in_vld && in_rdy;

  // Stage chain
  assign d_vld = {stg_vld[MAX_DEPTH-2:0], accept};

  always_comb begin
    d_data[0] = accept ? bus.in_data : '0;
    for (int unsigned k = 1; k < MAX_DEPTH; k++) d_data[k] = stg_data[k-1];
  end

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    lat_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_vld),
      .d_vld  (d_vld[k]),
      .d_data (d_data[k]),
      .q_vld  (stg_vld[k]),
      .q_data (stg_data[k])
    );
  end

  // Output tap: stage number dly_cur (1-based)
  assign tap     = TAP_W'(dly_cur - DLY_W'(1));
  assign out_vld = stg_vld[tap];

  // Request decode
  assign req_clamped = DLY_W'(clamp_dly(32'(bus.dly_val), MAX_DEPTH));
  assign req_bad     = dly_illegal(32'(bus.dly_val), MAX_DEPTH);

  // Look ahead by one cycle: the last beat leaving this cycle empties the pipe,
  // so APPLY follows the final old-delay beat directly.
  assign drained = (inflight == '0) || ((inflight == DLY_W'(1)) && out_vld);

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    dly_ack  = 1'b0;
    clr_vld  = 1'b0;
    case (state)
      ST_RUN: begin
        in_rdy = 1'b1;
        if (bus.dly_req) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drained) state_nx = ST_APPLY;
      end
      ST_APPLY: begin
        dly_ack  = 1'b1;
        clr_vld  = 1'b1;
        state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      dly_cur  <= DLY_W'(RST_DLY);
      pending  <= DLY_W'(RST_DLY);
      inflight <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state <= state_nx;
      case ({accept, out_vld})
        2'b10:   inflight <= inflight + DLY_W'(1);
        2'b01:   inflight <= inflight - DLY_W'(1);
        default: inflight <= inflight;
      endcase
      if (bus.dly_req && (state != ST_APPLY)) begin
        pending <= req_clamped;
        if (req_bad) cfg_err <= 1'b1;
      end
      if (state == ST_APPLY) dly_cur <= pending;
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = out_vld;
  assign bus.out_data = out_vld ? stg_data[tap] : '0;
  assign bus.dly_ack  = dly_ack;
  assign bus.dly_cur  = dly_cur;
  assign bus.busy     = (inflight != '0);
  assign bus.cfg_err  = cfg_err;

endmodule

// File: tb/tb_var_lat_pipe.sv
// Directed self-checking bench for var_lat_pipe (WIDTH=8, MAX_DEPTH=16, RST_DLY=3).
module tb_var_lat_pipe;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  var_lat_pipe_if #(.WIDTH(8), .DLY_W(5)) bus ();

  var_lat_pipe #(.WIDTH(8), .MAX_DEPTH(16), .RST_DLY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Delay change with an empty pipe; returns at t+3 (in_rdy back).
  task automatic req_empty(input logic [4:0] v);
    bus.dly_req = 1'b1;
    bus.dly_val = v;
    step();
    bus.dly_req = 1'b0;
    bus.dly_val = '0;
    step();
    step();
  endtask

  initial begin
    logic       ev;
    logic [7:0] ed;

    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.dly_req = 1'b0;
    bus.dly_val = '0;
    #2 rst = 1'b0;
    #1;

    // Reset values
    chk("rst_in_rdy",  32'(bus.in_rdy),   32'd1);
    chk("rst_out_vld", 32'(bus.out_vld),  32'd0);
    chk("rst_out_dat", 32'(bus.out_data), 32'd0);
    chk("rst_ack",     32'(bus.dly_ack),  32'd0);
    chk("rst_busy",    32'(bus.busy),     32'd0);
    chk("rst_cfg_err", 32'(bus.cfg_err),  32'd0);
    chk("rst_dly_cur", 32'(bus.dly_cur),  32'd3);
    step();
    step();
    rst = 1'b1;
    repeat (3) step();

    // 1: single beat, latency 3, zero data elsewhere
    bus.in_vld  = 1'b1;
    bus.in_data = 8'hA5;
    step();
    bus.in_vld  = 1'b0;
    bus.in_data = 8'hFF;
    chk("t1_busy", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      chk("t1_vld",  32'(bus.out_vld),  32'(k == 3));
      chk("t1_data", 32'(bus.out_data), (k == 3) ? 32'hA5 : 32'h0);
      step();
    end

    // 2: back-to-back 0x01..0x10
    for (int i = 0; i < 22; i++) begin
      bus.in_vld  = (i < 16);
      bus.in_data = 8'(i + 1);
      ev = (i >= 3) && (i < 19);
      ed = ev ? 8'(i - 2) : 8'h00;
      chk("t2_rdy",  32'(bus.in_rdy),   32'd1);
      chk("t2_vld",  32'(bus.out_vld),  32'(ev));
      chk("t2_data", 32'(bus.out_data), 32'(ed));
      step();
    end
    bus.in_vld = 1'b0;

    // 3: empty pipe, 3 -> 7
    chk("t3_rdy_t0", 32'(bus.in_rdy), 32'd1);
    bus.dly_req = 1'b1;
    bus.dly_val = 5'd7;
    step();
    bus.dly_req = 1'b0;
    bus.dly_val = '0;
    chk("t3_rdy_t1", 32'(bus.in_rdy),  32'd0);
    chk("t3_ack_t1", 32'(bus.dly_ack), 32'd0);
    chk("t3_cur_t1", 32'(bus.dly_cur), 32'd3);
    step();
    chk("t3_ack_t2", 32'(bus.dly_ack), 32'd1);
    chk("t3_rdy_t2", 32'(bus.in_rdy),  32'd0);
    step();
    chk("t3_ack_t3", 32'(bus.dly_ack), 32'd0);
    chk("t3_rdy_t3", 32'(bus.in_rdy),  32'd1);
    chk("t3_cur_t3", 32'(bus.dly_cur), 32'd7);
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h3C;
    step();
    bus.in_vld  = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk("t3_vld",  32'(bus.out_vld),  32'(k == 7));
      chk("t3_data", 32'(bus.out_data), (k == 7) ? 32'h3C : 32'h0);
      step();
    end

    // 4: beats in flight, 3 -> 12
    req_empty(5'd3);
    chk("t4_cur0", 32'(bus.dly_cur), 32'd3);
    for (int p = 0; p <= 16; p++) begin
      bus.in_vld  = (p <= 6);
      bus.in_data = (p <= 2) ? 8'(8'h11 * (p + 1)) : 8'hEE;
      bus.dly_req = (p == 2);
      bus.dly_val = 5'd12;
      ev = (p >= 3) && (p <= 5);
      ed = ev ? 8'(8'h11 * (p - 2)) : 8'h00;
      chk("t4_vld",  32'(bus.out_vld),  32'(ev));
      chk("t4_data", 32'(bus.out_data), 32'(ed));
      chk("t4_rdy",  32'(bus.in_rdy),   32'((p <= 2) || (p >= 7)));
      chk("t4_ack",  32'(bus.dly_ack),  32'(p == 6));
      chk("t4_busy", 32'(bus.busy),     32'((p >= 1) && (p <= 5)));
      chk("t4_cur",  32'(bus.dly_cur),  (p >= 7) ? 32'd12 : 32'd3);
      step();
    end
    bus.in_vld  = 1'b0;
    bus.dly_req = 1'b0;
    bus.dly_val = '0;

    // 5: clamping and sticky cfg_err
    chk("t5_err_pre", 32'(bus.cfg_err), 32'd0);
    req_empty(5'd0);
    chk("t5_cur_lo", 32'(bus.dly_cur), 32'd1);
    chk("t5_err_lo", 32'(bus.cfg_err), 32'd1);
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h5A;
    step();
    bus.in_vld  = 1'b0;
    chk("t5_l1_vld",  32'(bus.out_vld),  32'd1);
    chk("t5_l1_data", 32'(bus.out_data), 32'h5A);
    step();
    chk("t5_l1_vld2", 32'(bus.out_vld),  32'd0);
    req_empty(5'd20);
    chk("t5_cur_hi", 32'(bus.dly_cur), 32'd16);
    chk("t5_err_hi", 32'(bus.cfg_err), 32'd1);
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h96;
    step();
    bus.in_vld  = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      chk("t5_l16_vld",  32'(bus.out_vld),  32'(k == 16));
      chk("t5_l16_data", 32'(bus.out_data), (k == 16) ? 32'h96 : 32'h0);
      step();
    end
    // Second request during DRAIN overwrites pending; one ack only
    bus.dly_req = 1'b1;
    bus.dly_val = 5'd5;
    step();
    bus.dly_val = 5'd9;
    chk("t5_ow_ack1", 32'(bus.dly_ack), 32'd0);
    step();
    bus.dly_req = 1'b0;
    bus.dly_val = '0;
    chk("t5_ow_ack2", 32'(bus.dly_ack), 32'd1);
    step();
    chk("t5_ow_ack3", 32'(bus.dly_ack), 32'd0);
    chk("t5_ow_cur",  32'(bus.dly_cur), 32'd9);
    chk("t5_ow_err",  32'(bus.cfg_err), 32'd1);
    step();
    chk("t5_ow_ack4", 32'(bus.dly_ack), 32'd0);

    // 6: reset during DRAIN
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h77;
    step();
    bus.in_data = 8'h78;
    bus.dly_req = 1'b1;
    bus.dly_val = 5'd12;
    step();
    bus.in_vld  = 1'b0;
    bus.dly_req = 1'b0;
    bus.dly_val = '0;
    step();
    chk("t6_drain_rdy",  32'(bus.in_rdy), 32'd0);
    chk("t6_drain_busy", 32'(bus.busy),   32'd1);
    rst = 1'b0;
    #1;
    chk("t6_cur",     32'(bus.dly_cur),  32'd3);
    chk("t6_rdy",     32'(bus.in_rdy),   32'd1);
    chk("t6_vld",     32'(bus.out_vld),  32'd0);
    chk("t6_data",    32'(bus.out_data), 32'd0);
    chk("t6_busy",    32'(bus.busy),     32'd0);
    chk("t6_ack",     32'(bus.dly_ack),  32'd0);
    chk("t6_cfg_err", 32'(bus.cfg_err),  32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_ack_rst", 32'(bus.dly_ack), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t6_ack_post", 32'(bus.dly_ack), 32'd0);
      chk("t6_vld_post", 32'(bus.out_vld), 32'd0);
    end
    bus.in_vld  = 1'b1;
    bus.in_data = 8'hC3;
    step();
    bus.in_vld  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("t6_l3_vld",  32'(bus.out_vld),  32'(k == 3));
      chk("t6_l3_data", 32'(bus.out_data), (k == 3) ? 32'hC3 : 32'h0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
